// File: rtl/uart_cmd_pkg.sv
// Shared constants and FSM state type for the UART byte-command initiator.
// Command opcodes, script lengths and the sequencer state encoding.
package uart_cmd_pkg;

  localparam logic [7:0] CMD_UW_REG0  = 8'h40;
  localparam logic [7:0] CMD_UR_REG0  = 8'h50;
  localparam logic [7:0] CMD_SDRAM_WR = 8'hA0;
  localparam logic [7:0] CMD_SDRAM_RD = 8'hA1;

  localparam logic [3:0] WR_LEN = 4'd11;
  localparam logic [3:0] RD_LEN = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_TX,
    ST_GAP,
    ST_WAIT_RX,
    ST_RESP
  } state_t;

endpackage

// File: rtl/uart_cmd_script.sv
// Combinational script generator: maps a byte index plus the request fields
// to the command byte, an end-of-script flag and a readback-opcode flag.
module uart_cmd_script
  import uart_cmd_pkg::*;
(
  input  logic [3:0]  i_idx,
  input  logic        i_write,
  input  logic [23:0] i_addr,
  input  logic [15:0] i_wdata,
  output logic [7:0]  o_byte,
  output logic        o_last,
  output logic        o_is_readback
);

  always_comb begin
    o_byte        = '0;
    o_last        = 1'b0;
    o_is_readback = 1'b0;
    if (i_write) begin
      o_last = (i_idx == (WR_LEN - 4'd1));
      case (i_idx)
        4'd0:    o_byte = CMD_UW_REG0;
        4'd1:    o_byte = i_wdata[7:0];
        4'd2:    o_byte = CMD_UW_REG0 + 8'd1;
        4'd3:    o_byte = i_wdata[15:8];
        4'd4:    o_byte = CMD_UW_REG0 + 8'd2;
        4'd5:    o_byte = i_addr[7:0];
        4'd6:    o_byte = CMD_UW_REG0 + 8'd3;
        4'd7:    o_byte = i_addr[15:8];
        4'd8:    o_byte = CMD_UW_REG0 + 8'd4;
        4'd9:    o_byte = i_addr[23:16];
        4'd10:   o_byte = CMD_SDRAM_WR;
        default: o_byte = '0;
      endcase
    end else begin
      o_last = (i_idx == (RD_LEN - 4'd1));
      case (i_idx)
        4'd0:    o_byte = CMD_UW_REG0 + 8'd2;
        4'd1:    o_byte = i_addr[7:0];
        4'd2:    o_byte = CMD_UW_REG0 + 8'd3;
        4'd3:    o_byte = i_addr[15:8];
        4'd4:    o_byte = CMD_UW_REG0 + 8'd4;
        4'd5:    o_byte = i_addr[23:16];
        4'd6:    o_byte = CMD_SDRAM_RD;
        4'd7: begin
          o_byte        = CMD_UR_REG0;
          o_is_readback = 1'b1;
        end
        4'd8: begin
          o_byte        = CMD_UR_REG0 + 8'd1;
          o_is_readback = 1'b1;
        end
        default: o_byte = '0;
      endcase
    end
  end

endmodule

// File: rtl/uart_cmd_master.sv
// Host-side UART command initiator: turns single-word SDRAM requests into
// the MCU's register-load / execute / readback byte sequences.
module uart_cmd_master
  import uart_cmd_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 16,
  parameter int unsigned RX_TIMEOUT = 2000000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [23:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_timeout,
  output logic        tx_send,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        busy
);

  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
  localparam int unsigned TW = $clog2(RX_TIMEOUT + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(RX_TIMEOUT - 1);

  state_t        r_state, w_next;
  logic          r_ready_en;
  logic [3:0]    r_idx;
  logic          r_write;
  logic [23:0]   r_addr;
  logic [15:0]   r_wdata;
  logic          r_script_done;
  logic          r_armed, r_have, r_rb_hi;
  logic [GW-1:0] r_gap_cnt;
  logic [TW-1:0] r_tmo_cnt;
  logic [7:0]    r_tx_data;
  logic [15:0]   r_rdata;
  logic          r_timeout;

  logic          w_idle, w_accept;
  logic [3:0]    w_idx;
  logic          w_wr;
  logic [23:0]   w_addr;
  logic [15:0]   w_wdata;
  logic [7:0]    w_byte;
  logic          w_last, w_rb;
  logic          w_cap, w_cap_hi, w_gap_end, w_tmo_end;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_accept = req_valid && req_ready;

  // In IDLE the script is fed from the live request so the first byte can be
  // registered into tx_data in the same cycle the request is accepted.
  assign w_idx   = w_idle ? 4'd0 : r_idx;
  assign w_wr    = w_idle ? req_write : r_write;
  assign w_addr  = w_idle ? req_addr : r_addr;
  assign w_wdata = w_idle ? req_wdata : r_wdata;

  uart_cmd_script u_script (
    .i_idx         (w_idx),
    .i_write       (w_wr),
    .i_addr        (w_addr),
    .i_wdata       (w_wdata),
    .o_byte        (w_byte),
    .o_last        (w_last),
    .o_is_readback (w_rb)
  );

  // Capture window opens on the tx_send cycle of a readback opcode.
  assign w_cap     = rx_valid && !r_have && (r_armed || (r_state == ST_SEND && w_rb));
  assign w_cap_hi  = r_armed ? r_rb_hi : w_byte[0];
  assign w_gap_end = (r_gap_cnt == GAP_LAST);
  assign w_tmo_end = (r_tmo_cnt == TMO_LAST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_accept) w_next = ST_SEND;
      ST_SEND:    w_next = ST_WAIT_TX;
      ST_WAIT_TX: if (tx_done) w_next = r_armed ? ST_WAIT_RX : ST_GAP;
      ST_GAP:     if (w_gap_end) w_next = r_script_done ? ST_RESP : ST_SEND;
      ST_WAIT_RX: begin
        if (r_have || w_cap) w_next = ST_GAP;
        else if (w_tmo_end)  w_next = ST_RESP;
      end
      ST_RESP:    w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_ready_en    <= 1'b0;
      r_idx         <= '0;
      r_write       <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_script_done <= 1'b0;
      r_armed       <= 1'b0;
      r_have        <= 1'b0;
      r_rb_hi       <= 1'b0;
      r_gap_cnt     <= '0;
      r_tmo_cnt     <= '0;
      r_tx_data     <= '0;
      r_rdata       <= '0;
      r_timeout     <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      r_gap_cnt  <= (r_state == ST_GAP) ? r_gap_cnt + GW'(1) : '0;
      r_tmo_cnt  <= (r_state == ST_WAIT_RX) ? r_tmo_cnt + TW'(1) : '0;
      if (w_next == ST_SEND) r_tx_data <= w_byte;
      if (w_accept) begin
        r_write       <= req_write;
        r_addr        <= req_addr;
        r_wdata       <= req_wdata;
        r_idx         <= '0;
        r_script_done <= 1'b0;
        r_rdata       <= '0;
        r_timeout     <= 1'b0;
      end
      if (r_state == ST_WAIT_TX && tx_done) begin
        r_idx         <= r_idx + 4'd1;
        r_script_done <= w_last;
      end
      if (r_state == ST_SEND && w_rb) begin
        r_armed <= 1'b1;
        r_rb_hi <= w_byte[0];
      end
      if (w_cap) begin
        r_have <= 1'b1;
        if (w_cap_hi) r_rdata[15:8] <= rx_data;
        else          r_rdata[7:0]  <= rx_data;
      end
      if (r_state == ST_WAIT_RX && w_next != ST_WAIT_RX) begin
        r_armed <= 1'b0;
        r_have  <= 1'b0;
      end
      if (r_state == ST_WAIT_RX && w_next == ST_RESP) begin
        r_timeout <= 1'b1;
        r_rdata   <= '0;
      end
    end
  end

  assign req_ready   = r_ready_en && w_idle;
  assign busy        = !w_idle;
  assign tx_send     = (r_state == ST_SEND);
  assign tx_data     = r_tx_data;
  assign rsp_valid   = (r_state == ST_RESP);
  assign rsp_rdata   = r_rdata;
  assign rsp_timeout = r_timeout;

endmodule

// File: tb/tb_uart_cmd_master.sv
// Self-checking bench for uart_cmd_master with a transceiver/MCU responder
// and a byte-script reference model built from the protocol rules.
module tb_uart_cmd_master;

  localparam int unsigned GAP = 16;
  localparam int unsigned TMO = 500;
  typedef logic [7:0] bq_t[$];

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        req_valid, req_ready, req_write;
  logic [23:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid, rsp_timeout;
  logic [15:0] rsp_rdata;
  logic        tx_send, tx_done, rx_valid, busy;
  logic [7:0]  tx_data, rx_data;

  always #5 sys_clk = ~sys_clk;

  uart_cmd_master #(.GAP_CYCLES(GAP), .RX_TIMEOUT(TMO)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_timeout (rsp_timeout),
    .tx_send     (tx_send),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .busy        (busy)
  );

  int n_asserts = 0;
  int n_fail    = 0;

  // Responder-side observations (written only by the responder process)
  bq_t         sent_q, done_q;
  int          cyc = 0, last_done_cyc = 0, rsp_cnt = 0, rsp_cyc = 0, stray_done = 0;
  logic [15:0] rsp_rd_s = '0;
  logic        rsp_to_s = 1'b0, ready_at_rsp = 1'b0;

  // Responder configuration (written only by the main sequence)
  // rep_mode per readback byte: 0 = silent, 1 = reply after tx_done, 2 = reply 3 cycles after tx_send
  int          tx_delay = 100;
  int          rep_mode [2] = '{1, 1};
  logic [7:0]  rep_val [2] = '{8'h00, 8'h00};
  logic        stray_42 = 1'b0;
  int          stray_req = 0;

  task automatic tick();
    @(negedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected bytes: register loads for the 40-bit {addr, wdata} field, then opcodes.
  task automatic build_exp(input logic wr, input logic [23:0] a, input logic [15:0] d, output bq_t q);
    logic [39:0] v;
    v = {a, d};
    q = {};
    for (int n = (wr ? 0 : 2); n < 5; n++) begin
      q.push_back(8'(8'h40 + n));
      q.push_back(v[8*n +: 8]);
    end
    if (wr) q.push_back(8'hA0);
    else begin
      q.push_back(8'hA1);
      q.push_back(8'h50);
      q.push_back(8'h51);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_req_ready"},   32'(req_ready),   32'd0);
    check({tag, "_rsp_valid"},   32'(rsp_valid),   32'd0);
    check({tag, "_rsp_rdata"},   32'(rsp_rdata),   32'd0);
    check({tag, "_rsp_timeout"}, 32'(rsp_timeout), 32'd0);
    check({tag, "_tx_send"},     32'(tx_send),     32'd0);
    check({tag, "_tx_data"},     32'(tx_data),     32'd0);
    check({tag, "_busy"},        32'(busy),        32'd0);
  endtask

  task automatic run_req(input logic wr, input logic [23:0] a, input logic [15:0] d, input string tag);
    bq_t         exp;
    int          k, sb, db, rb;
    logic [15:0] exp_rd;
    logic        exp_to;
    build_exp(wr, a, d, exp);
    exp_to = !wr && (rep_mode[1] == 0);
    exp_rd = (wr || exp_to) ? 16'h0000 : {rep_val[1], rep_val[0]};
    sb = sent_q.size();
    db = done_q.size();
    rb = rsp_cnt;
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    tick();
    req_valid = 1'b0;
    req_write = 1'($urandom_range(0, 1));
    req_addr  = 24'($urandom);
    req_wdata = 16'($urandom);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    k = 0;
    while (rsp_cnt == rb && k < 20000) begin
      tick();
      k++;
    end
    check({tag, "_rsp_in_time"}, 32'(k < 20000), 32'd1);
    repeat (3) tick();
    check({tag, "_nbytes"}, 32'(sent_q.size() - sb), 32'(exp.size()));
    for (int i = 0; i < exp.size() && sb + i < sent_q.size(); i++)
      check({tag, "_txbyte"}, 32'(sent_q[sb+i]), 32'(exp[i]));
    check({tag, "_ndone"}, 32'(done_q.size() - db), 32'(exp.size()));
    for (int i = 0; i < exp.size() && db + i < done_q.size(); i++)
      check({tag, "_donebyte"}, 32'(done_q[db+i]), 32'(exp[i]));
    check({tag, "_rsp_count"}, 32'(rsp_cnt - rb), 32'd1);
    check({tag, "_rdata"},     32'(rsp_rd_s),     32'(exp_rd));
    check({tag, "_timeout"},   32'(rsp_to_s),     32'(exp_to));
    check({tag, "_ready_at_rsp"}, 32'(ready_at_rsp), 32'd0);
    check({tag, "_ready_after"},  32'(req_ready),    32'd1);
    check({tag, "_busy_after"},   32'(busy),         32'd0);
    if (wr)          check({tag, "_latency"}, 32'(rsp_cyc - last_done_cyc), 32'(GAP + 1));
    else if (exp_to) check({tag, "_latency"}, 32'(rsp_cyc - last_done_cyc), 32'(TMO + 1));
  endtask

  // Transceiver + MCU responder, acting on the falling edge.
  initial begin : responder
    int         tx_cnt, rx_cnt;
    logic [7:0] rx_pend;
    tx_cnt   = -1;
    rx_cnt   = -1;
    rx_pend  = '0;
    tx_done  = 1'b0;
    rx_valid = 1'b0;
    rx_data  = '0;
    forever begin
      @(negedge sys_clk);
      cyc++;
      tx_done  = 1'b0;
      rx_valid = 1'b0;
      if (rsp_valid) begin
        rsp_cnt++;
        rsp_cyc      = cyc;
        rsp_rd_s     = rsp_rdata;
        rsp_to_s     = rsp_timeout;
        ready_at_rsp = req_ready;
      end
      if (stray_req != stray_done) begin
        rx_valid = 1'b1;
        rx_data  = 8'($urandom);
        stray_done++;
      end
      if (rx_cnt > 0) rx_cnt--;
      if (rx_cnt == 0) begin
        rx_valid = 1'b1;
        rx_data  = rx_pend;
        rx_cnt   = -1;
      end
      if (tx_cnt > 0) tx_cnt--;
      if (tx_cnt == 0) begin
        tx_done = 1'b1;
        done_q.push_back(tx_data);
        last_done_cyc = cyc;
        tx_cnt = -1;
        if (tx_data[7:1] == 7'h28 && rep_mode[tx_data[0]] == 1) begin
          rx_cnt  = int'($urandom_range(2, 7));
          rx_pend = rep_val[tx_data[0]];
        end
      end
      if (tx_send) begin
        sent_q.push_back(tx_data);
        tx_cnt = tx_delay;
        if (tx_data[7:1] == 7'h28 && rep_mode[tx_data[0]] == 2) begin
          rx_cnt  = 3;
          rx_pend = rep_val[tx_data[0]];
        end
        if (tx_data == 8'h42 && stray_42) begin
          rx_cnt  = 5;
          rx_pend = 8'($urandom);
        end
      end
    end
  end

  initial begin : main
    int base, k;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    tick();
    tick();
    check_reset("rst_init");
    sys_rst = 1'b0;
    tick();
    check("rst_ready_after_release", 32'(req_ready), 32'd1);

    run_req(1'b1, 24'h123456, 16'hBEEF, "wr_dir");
    rep_val = '{8'h5A, 8'hC3};
    run_req(1'b0, 24'h000010, 16'h0000, "rd_dir");

    rep_mode = '{2, 1};
    rep_val  = '{8'($urandom), 8'($urandom)};
    run_req(1'b0, 24'($urandom), 16'($urandom), "rd_early");

    rep_mode = '{1, 0};
    rep_val  = '{8'($urandom), 8'($urandom)};
    run_req(1'b0, 24'($urandom), 16'($urandom), "rd_tmo");
    rep_mode = '{1, 1};
    run_req(1'b1, 24'($urandom), 16'($urandom), "wr_after_tmo");

    stray_req++;
    repeat (3) tick();
    check("stray_idle_busy", 32'(busy), 32'd0);
    stray_42 = 1'b1;
    rep_val  = '{8'($urandom), 8'($urandom)};
    run_req(1'b0, 24'($urandom), 16'($urandom), "rd_stray");
    stray_42 = 1'b0;

    // Reset in the middle of the 0x43 byte of a write
    base      = sent_q.size();
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 24'($urandom);
    req_wdata = 16'($urandom);
    tick();
    req_valid = 1'b0;
    k = 0;
    while (sent_q.size() < base + 7 && k < 5000) begin
      tick();
      k++;
    end
    check("rstmid_reached", 32'(sent_q.size() >= base + 7), 32'd1);
    if (sent_q.size() >= base + 7) check("rstmid_byte43", 32'(sent_q[base+6]), 32'h43);
    repeat (10) tick();
    sys_rst = 1'b1;
    tick();
    check_reset("rstmid");
    repeat (3) tick();
    sys_rst = 1'b0;
    base = rsp_cnt;
    k    = sent_q.size();
    repeat (150) tick();
    check("rstmid_no_rsp",  32'(rsp_cnt - base),     32'd0);
    check("rstmid_no_send", 32'(sent_q.size() - k),  32'd0);
    check("rstmid_idle",    32'(busy),               32'd0);
    run_req(1'b1, 24'($urandom), 16'($urandom), "wr_after_rst");

    for (int i = 0; i < 4; i++) begin
      tx_delay = int'($urandom_range(4, 40));
      rep_mode = '{int'($urandom_range(1, 2)), 1};
      rep_val  = '{8'($urandom), 8'($urandom)};
      run_req(1'($urandom_range(0, 1)), 24'($urandom), 16'($urandom), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
